reg_fetch: RTL
==============

// Module: reg_fetch
// PURPOSE
// - Operand-fetch stage for the dual-issue (even/odd) pipes: the read side of the 128x128 register file written by writeback.
// - Per pipe: reads up to 3 sources (ra, rb, rc) and overrides them with in-flight results from the forwarding network.
// - Registers the operands, target and control for the execute stage.
// - Sits between issue/decode and the first execute stage. Latency 1 cycle.
// PARAMETERS
// - DATA_W   128  register/result width
// - REG_AW   7    register address width (128 registers)
// - PKT_W    150  stage packet width (layout in package)
// - NUM_FWD  4    forwarding taps per pipe; index 0 = youngest
// - CTRL_W   14   opaque control pass-through width (opcode/unit/latency)
// PORTS
// - clk        in   1                       clock; all state on posedge
// - rst        in   1                       synchronous, active-high reset
// - stall      in   1                       hold output register
// - flush      in   1                       kill both output slots
// - in_vld_e   in   1                       even instruction present
// - in_vld_o   in   1                       odd instruction present
// - ra_e, rb_e, rc_e / ra_o, rb_o, rc_o   in   REG_AW each   source addresses
// - rt_e, rt_o in   REG_AW                  target address (pass-through)
// - ctrl_e, ctrl_o  in   CTRL_W             control (pass-through)
// - reg_file   in   [127:0][DATA_W-1:0]     architectural register file
// - fwd_e, fwd_o    in   [NUM_FWD-1:0][PKT_W-1:0]   stage packets, even/odd pipe
// - out_vld_e, out_vld_o   out  1           slot valid
// - opa_e, opb_e, opc_e / opa_o, opb_o, opc_o   out  DATA_W each   operands
// - rt_out_e, rt_out_o     out  REG_AW      target
// - ctrl_out_e, ctrl_out_o out  CTRL_W      control
// BEHAVIOUR
// - Packet layout (package): [127:0] result, [134:128] rt, [135] wr_en, [149:136] ctrl.
// - Reset: all outputs, and held source addresses, go to 0 on the first posedge with rst=1. rst has priority over flush and stall.
// - Operand resolution, per source, combinational:
//   - scan taps 0..NUM_FWD-1; first tap with wr_en=1 and rt == source address wins.
//   - within a tap, an odd-pipe match beats an even-pipe match (matches writeback order: odd write lands last).
//   - no match: reg_file[source].
// - Tap NUM_FWD-1 is the packet being written by writeback this edge, so there is no read/write race.
// - Intra-pair dependency (odd source = even rt in the same input pair) is not forwarded; issue must not pair such instructions.
// - Register 0 is not special; it is forwarded like any other register.
// - Normal cycle (no stall/flush):
//   - out_vld_x <= in_vld_x.
//   - rt, ctrl and source addresses are captured.
//   - operands are captured from resolution of the input addresses.
// - stall=1:
//   - vld, rt, ctrl and held source addresses are frozen; inputs are ignored (upstream holds them).
//   - operands re-resolve every stall cycle using the held addresses, so results arriving on the taps during the stall are picked up.
//   - an invalid slot keeps operands unchanged.
// - flush=1 (no rst): out_vld_e and out_vld_o <= 0 next edge; data fields don't care. Flush beats stall.
// - Simultaneous stall and flush: slots cleared; stall is ignored for that edge.
// - Invalid input slot: out_vld=0; data fields may update; downstream must ignore them.
// STRUCTURE
// - Package reg_fetch_pkg:
//   - PKT_W, field offsets (RES_LSB=0, RT_LSB=128, WE_BIT=135, CTRL_LSB=136)
//   - typedef stg_pkt_t (packed struct)
//   - typedef reg_addr_t
// - One sub-module, fwd_mux:
//   - inputs: one address, reg_file, both tap arrays
//   - output: resolved DATA_W value
//   - six instances (3 sources x 2 pipes)
// - Top: output register, held-address register, and stall/flush control.
// TESTING
// 1. Plain read: reg_file[5]=0xA5.., no taps valid, ra_e=5, in_vld_e=1 -> next cycle opa_e=0xA5.., out_vld_e=1.
// 2. Forward priority: fwd_e[0] rt=5 data=0x11, fwd_e[2] rt=5 data=0x22, reg_file[5]=0x33 -> opa_e=0x11.
//    Repeat with fwd_o[0] rt=5 data=0x44 -> 0x44.
// 3. Writeback tap: fwd_o[3] rt=9 wr_en=1 data=0x77, reg_file[9]=0 -> opb_o=0x77.
//    Same with wr_en=0 -> 0.
// 4. Stall refresh: capture rc_e=12 (value 0x1); stall 3 cycles; in cycle 2 fwd_e[1] rt=12 data=0x99.
//    -> rc-operand becomes 0x99 and stays 0x99; rt/ctrl/out_vld unchanged.
//    Changing inputs during the stall has no effect.
// 5. Flush vs stall: stall=1, flush=1 with both slots valid -> next cycle out_vld_e=out_vld_o=0.
// 6. Reset mid-stream: rst=1 while stall=1 and valid slots -> all outputs 0 next edge.
//    First input after release passes normally.

Source files
------------

// File: rtl/reg_fetch_pkg.sv
// Shared widths, forwarding packet layout and slot state for the operand-fetch stage.
// Packet fields are located by offset so every consumer agrees on one layout.
package reg_fetch_pkg;

   localparam int DATA_W   = 128;
   localparam int REG_AW   = 7;
   localparam int NUM_REGS = 128;
   localparam int NUM_FWD  = 4;
   localparam int CTRL_W   = 14;
   localparam int NUM_SRC  = 3;

   localparam int RES_LSB  = 0;
   localparam int RT_LSB   = RES_LSB + DATA_W;
   localparam int WE_BIT   = RT_LSB + REG_AW;
   localparam int CTRL_LSB = WE_BIT + 1;
   localparam int PKT_W    = CTRL_LSB + CTRL_W;

   typedef logic [REG_AW-1:0] reg_addr_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic              wr_en;
      reg_addr_t         rt;
      logic [DATA_W-1:0] result;
   } stg_pkt_t;

   // One execute-bound slot: control, target, held source addresses and operands.
   typedef struct packed {
      logic                             vld;
      reg_addr_t                        rt;
      logic [CTRL_W-1:0]                ctrl;
      reg_addr_t [NUM_SRC-1:0]          src;
      logic [NUM_SRC-1:0][DATA_W-1:0]   opnd;
   } slot_t;

   function automatic logic tap_hit(input logic [PKT_W-1:0] pkt, input reg_addr_t addr);
      return pkt[WE_BIT] && (pkt[RT_LSB +: REG_AW] == addr);
   endfunction

   function automatic logic [DATA_W-1:0] tap_result(input logic [PKT_W-1:0] pkt);
      return pkt[RES_LSB +: DATA_W];
   endfunction

endpackage

// File: rtl/reg_fetch_fwd_mux.sv
// Resolves one source operand: youngest matching forwarding tap wins, odd pipe
// beats even within a tap, otherwise the architectural register file is read.
module fwd_mux
   import reg_fetch_pkg::*;
(
   input  reg_addr_t                          addr,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]    reg_file,
   input  logic [NUM_FWD-1:0][PKT_W-1:0]      fwd_e,
   input  logic [NUM_FWD-1:0][PKT_W-1:0]      fwd_o,
   output logic [DATA_W-1:0]                  value
);

   // Walk from oldest to youngest so the last assignment is the highest-priority hit.
   // NOTE: combinational logic uses blocking assignments and writes every output first so no latch is inferred.
   always_comb begin
      value = reg_file[addr];
      for (int t = NUM_FWD - 1; t >= 0; t--) begin
         if (tap_hit(fwd_e[t], addr)) value = tap_result(fwd_e[t]);
         if (tap_hit(fwd_o[t], addr)) value = tap_result(fwd_o[t]);
      end
   end

   // Control fields of forwarded packets are irrelevant to operand resolution.
   logic unused_ctrl;
   always_comb begin
      unused_ctrl = 1'b0;
      for (int t = 0; t < NUM_FWD; t++) begin
         unused_ctrl = unused_ctrl ^ (^fwd_e[t][PKT_W-1:CTRL_LSB]) ^ (^fwd_o[t][PKT_W-1:CTRL_LSB]);
      end
   end

endmodule

// File: rtl/reg_fetch.sv
// Operand-fetch stage for the even/odd pipes: reads three sources per pipe with
// forwarding and registers operands, target and control for execute (1-cycle latency).
module reg_fetch
   import reg_fetch_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              stall,
   input  logic                              flush,
   input  logic                              in_vld_e,
   input  logic                              in_vld_o,
   input  reg_addr_t                         ra_e,
   input  reg_addr_t                         rb_e,
   input  reg_addr_t                         rc_e,
   input  reg_addr_t                         ra_o,
   input  reg_addr_t                         rb_o,
   input  reg_addr_t                         rc_o,
   input  reg_addr_t                         rt_e,
   input  reg_addr_t                         rt_o,
   input  logic [CTRL_W-1:0]                 ctrl_e,
   input  logic [CTRL_W-1:0]                 ctrl_o,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]   reg_file,
   input  logic [NUM_FWD-1:0][PKT_W-1:0]     fwd_e,
   input  logic [NUM_FWD-1:0][PKT_W-1:0]     fwd_o,
   output logic                              out_vld_e,
   output logic                              out_vld_o,
   output logic [DATA_W-1:0]                 opa_e,
   output logic [DATA_W-1:0]                 opb_e,
   output logic [DATA_W-1:0]                 opc_e,
   output logic [DATA_W-1:0]                 opa_o,
   output logic [DATA_W-1:0]                 opb_o,
   output logic [DATA_W-1:0]                 opc_o,
   output reg_addr_t                         rt_out_e,
   output reg_addr_t                         rt_out_o,
   output logic [CTRL_W-1:0]                 ctrl_out_e,
   output logic [CTRL_W-1:0]                 ctrl_out_o
);

   // Index 0 = even pipe, 1 = odd pipe; source index 0/1/2 = ra/rb/rc.
   slot_t [1:0]                            slot_d, slot_q;
   reg_addr_t [1:0][NUM_SRC-1:0]           in_src, rd_addr;
   logic [1:0][NUM_SRC-1:0][DATA_W-1:0]    rd_data;
   logic [1:0]                             in_vld;
   reg_addr_t [1:0]                        in_rt;
   logic [1:0][CTRL_W-1:0]                 in_ctrl;

   assign in_src[0]  = {rc_e, rb_e, ra_e};
   assign in_src[1]  = {rc_o, rb_o, ra_o};
   assign in_vld     = {in_vld_o, in_vld_e};
   assign in_rt      = {rt_o, rt_e};
   assign in_ctrl    = {ctrl_o, ctrl_e};

   // While stalled the held addresses re-resolve so late-arriving results are picked up.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            rd_addr[p][s] = stall ? slot_q[p].src[s] : in_src[p][s];
         end
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_pipe
      for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
         fwd_mux u_fwd_mux (
            .addr     (rd_addr[p][s]),
            .reg_file (reg_file),
            .fwd_e    (fwd_e),
            .fwd_o    (fwd_o),
            .value    (rd_data[p][s])
         );
      end
   end

   // Flush beats stall; a stalled slot only refreshes operands when it holds a valid instruction.
   always_comb begin
      slot_d = slot_q;
      if (flush) begin
         for (int p = 0; p < 2; p++) slot_d[p].vld = 1'b0;
      end else if (stall) begin
         for (int p = 0; p < 2; p++) begin
            if (slot_q[p].vld) slot_d[p].opnd = rd_data[p];
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            slot_d[p].vld  = in_vld[p];
            slot_d[p].rt   = in_rt[p];
            slot_d[p].ctrl = in_ctrl[p];
            slot_d[p].src  = in_src[p];
            slot_d[p].opnd = rd_data[p];
         end
      end
   end

   // NOTE: operand data is reset along with control because every output must read 0 after reset.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) slot_q <= '0;
      else     slot_q <= slot_d;
   end

   assign out_vld_e  = slot_q[0].vld;
   assign out_vld_o  = slot_q[1].vld;
   assign opa_e      = slot_q[0].opnd[0];
   assign opb_e      = slot_q[0].opnd[1];
   assign opc_e      = slot_q[0].opnd[2];
   assign opa_o      = slot_q[1].opnd[0];
   assign opb_o      = slot_q[1].opnd[1];
   assign opc_o      = slot_q[1].opnd[2];
   assign rt_out_e   = slot_q[0].rt;
   assign rt_out_o   = slot_q[1].rt;
   assign ctrl_out_e = slot_q[0].ctrl;
   assign ctrl_out_o = slot_q[1].ctrl;

endmodule
